// File: rtl/lfsr_rng.sv
// lfsr_rng: XNOR-feedback Galois-free (Fibonacci) LFSR random source with a
// bounded-value generator that uses rejection sampling with a fallback draw.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     free-runs the LFSR while high
//   seed_load  loads seed into the LFSR (all-ones seed loads all-zeros)
//   seed       seed value, WIDTH bits
//   req        requests one value in [lo, hi]; ignored while busy
//   lo, hi     inclusive bounds, OUT_W bits
//   state      raw LFSR state register
//   value      registered bounded result, held until the next valid
//   valid      one-cycle pulse marking a new value
//   busy       high while a request is being drawn
//   error      one-cycle pulse for a request with lo > hi
module lfsr_rng #(
   parameter int WIDTH   = 16,
   parameter int OUT_W   = 8,
   parameter int MAX_TRY = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             req,
   input  logic [OUT_W-1:0] lo,
   input  logic [OUT_W-1:0] hi,
   output logic [WIDTH-1:0] state,
   output logic [OUT_W-1:0] value,
   output logic             valid,
   output logic             busy,
   output logic             error
);

   localparam int          TRY_W = (MAX_TRY < 2) ? 1 : $clog2(MAX_TRY + 1);
   localparam int unsigned OUT_U = OUT_W;

   generate
      if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
         $error("lfsr_rng: WIDTH must be 8, 16, 24 or 32");
      end
      if (OUT_W > WIDTH) begin : g_bad_out_w
         $error("lfsr_rng: OUT_W must not exceed WIDTH");
      end
      if (MAX_TRY < 1) begin : g_bad_max_try
         $error("lfsr_rng: MAX_TRY must be at least 1");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      DRAW
   } fsm_t;

   fsm_t             fsm;
   logic             fb;
   logic [OUT_W-1:0] lo_q;
   logic [OUT_W-1:0] span_q;
   logic [OUT_W-1:0] mask_q;
   logic [OUT_W-1:0] span_c;
   logic [OUT_W-1:0] mask_c;
   logic [OUT_W-1:0] cand;
   logic [TRY_W-1:0] tries;

   // XNOR taps make all-ones the lockup state, so all-zeros is a legal start.
   generate
      if (WIDTH == 8) begin : g_tap8
         assign fb = ~(state[7] ^ state[5] ^ state[4] ^ state[3]);
      end else if (WIDTH == 16) begin : g_tap16
         assign fb = ~(state[15] ^ state[14] ^ state[12] ^ state[3]);
      end else if (WIDTH == 24) begin : g_tap24
         assign fb = ~(state[23] ^ state[22] ^ state[21] ^ state[16]);
      end else if (WIDTH == 32) begin : g_tap32
         assign fb = ~(state[31] ^ state[21] ^ state[1] ^ state[0]);
      end else begin : g_tap_none
         assign fb = 1'b0;
      end
   endgenerate

   assign busy   = (fsm == DRAW);
   assign span_c = hi - lo;
   assign cand   = state[OUT_W-1:0] & mask_q;

   // Smear the span's highest set bit downward: smallest 2^k-1 >= span.
   always_comb begin
      mask_c = span_c;
      for (int unsigned i = 0; i < OUT_U; i++) begin
         mask_c = mask_c | (mask_c >> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= '0;
      end else if (seed_load) begin
         state <= (seed == '1) ? '0 : seed;
      end else if (enable || fsm == DRAW) begin
         state <= {state[WIDTH-2:0], fb};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm    <= IDLE;
         lo_q   <= '0;
         span_q <= '0;
         mask_q <= '0;
         tries  <= '0;
         value  <= '0;
         valid  <= 1'b0;
         error  <= 1'b0;
      end else begin
         valid <= 1'b0;
         error <= 1'b0;
         case (fsm)
            IDLE: begin
               if (req) begin
                  if (lo > hi) begin
                     error <= 1'b1;
                  end else begin
                     lo_q   <= lo;
                     span_q <= span_c;
                     mask_q <= mask_c;
                     tries  <= TRY_W'(1);
                     fsm    <= DRAW;
                  end
               end
            end
            DRAW: begin
               if (cand <= span_q) begin
                  value <= lo_q + cand;
                  valid <= 1'b1;
                  fsm   <= IDLE;
               end else if (tries == TRY_W'(MAX_TRY)) begin
                  // cand <= mask and mask>>1 < span, so cand>>1 stays in range.
                  value <= lo_q + (cand >> 1);
                  valid <= 1'b1;
                  fsm   <= IDLE;
               end else begin
                  tries <= tries + TRY_W'(1);
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
